// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the data-memory arbiter    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MODE_W  = 3'b001;
    localparam logic [2:0] MODE_H  = 3'b010;
    localparam logic [2:0] MODE_B  = 3'b011;
    localparam logic [2:0] MODE_HU = 3'b100;
    localparam logic [2:0] MODE_BU = 3'b101;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      mode;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } cmd_t;

    function automatic logic mode_valid(input logic [2:0] mode);
        return mode inside {MODE_W, MODE_H, MODE_B, MODE_HU, MODE_BU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin pick, one-hot grant                |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic [0:0] last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            // On a tie the port that did not win last time goes first.
            gnt_o = last_i[0] ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : shares the data memory between pipeline and debug port|
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] STATUS_ADDR = 'h100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [2:0]       mode0_i,
    input  logic [2:0]       mode1_i,
    input  logic [WIDTH-1:0] addr0_i,
    input  logic [WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0] wdata0_i,
    input  logic [WIDTH-1:0] wdata1_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             err_o,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    output logic [2:0]       mem_mode,
    input  logic [WIDTH-1:0] mem_RD
);

    arb_state_t       state_q, state_d;
    logic [0:0]       last_q, last_d;
    cmd_t             cmd_q, cmd_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [1:0]       w_gnt;
    logic             w_cmd_ok;

    rr_arbiter2 u_rr (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (w_gnt)
    );

    // The status address is a read-only trigger, so stores to it are refused.
    assign w_cmd_ok = mode_valid(cmd_q.mode) && !(cmd_q.we && (cmd_q.addr == STATUS_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cmd_q    <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cmd_d    = cmd_q;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        err_d    = err_q;
        gnt_o    = 2'b00;
        mem_A    = '0;
        mem_WD   = '0;
        mem_WE   = 1'b0;
        mem_mode = 3'b000;

        case (state_q)
            IDLE: begin
                gnt_o = w_gnt;
                if (w_gnt != 2'b00) begin
                    last_d[0] = w_gnt[1];
                    state_d   = ACCESS;
                    if (w_gnt[1]) begin
                        cmd_d.we    = we_i[1];
                        cmd_d.mode  = mode1_i;
                        cmd_d.addr  = addr1_i;
                        cmd_d.wdata = wdata1_i;
                    end else begin
                        cmd_d.we    = we_i[0];
                        cmd_d.mode  = mode0_i;
                        cmd_d.addr  = addr0_i;
                        cmd_d.wdata = wdata0_i;
                    end
                end
            end
            ACCESS: begin
                mem_A    = cmd_q.addr;
                mem_WD   = cmd_q.wdata;
                mem_mode = cmd_q.mode;
                mem_WE   = cmd_q.we && w_cmd_ok;
                // last_q already names the port being served.
                rvalid_d = last_q[0] ? 2'b10 : 2'b01;
                rdata_d  = (!cmd_q.we && w_cmd_ok) ? mem_RD : '0;
                err_d    = !w_cmd_ok;
                state_d  = IDLE;
            end
        endcase
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : timing-level model plus directed literal checks    |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_i = '0, we_i = '0;
    logic [2:0]  mode0_i = '0, mode1_i = '0;
    logic [31:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
    logic [31:0] mem_RD = '0;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o, mem_A, mem_WD;
    logic        err_o, mem_WE;
    logic [2:0]  mem_mode;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dmem_arbiter #(.WIDTH(32), .STATUS_ADDR(32'h100)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
        .mode0_i(mode0_i), .mode1_i(mode1_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
        .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .mem_A(mem_A), .mem_WD(mem_WD),
        .mem_WE(mem_WE), .mem_mode(mem_mode), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: timing rules only -- grant at N, memory access at N+1, response at N+2.
    int          free_cyc, acc_cyc, rsp_cyc, m_last, acc_port, rsp_port, w;
    bit          acc_pend, rsp_pend, acc_we, rsp_err, ok;
    logic [2:0]  acc_mode;
    logic [31:0] acc_addr, acc_wdata, rsp_rdata;
    logic [1:0]  e_gnt, e_rv;

    task automatic model_reset();
        free_cyc = 0; acc_pend = 0; rsp_pend = 0; m_last = 1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("rst_rvalid", {30'd0, rvalid_o}, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_err", {31'd0, err_o}, 0);
            chk("rst_memWE", {31'd0, mem_WE}, 0);
            chk("rst_memA", mem_A, 0);
        end else begin
            e_rv = 2'b00;
            if (rsp_pend && rsp_cyc == cyc) begin
                e_rv = (rsp_port == 1) ? 2'b10 : 2'b01;
                chk("m_rdata", rdata_o, rsp_rdata);
                chk("m_err", {31'd0, err_o}, {31'd0, rsp_err});
                rsp_pend = 0;
            end
            chk("m_rvalid", {30'd0, rvalid_o}, {30'd0, e_rv});

            if (acc_pend && acc_cyc == cyc) begin
                ok = (acc_mode >= 3'd1 && acc_mode <= 3'd5) && !(acc_we && acc_addr == 32'h100);
                chk("m_memA", mem_A, acc_addr);
                chk("m_memWD", mem_WD, acc_wdata);
                chk("m_memmode", {29'd0, mem_mode}, {29'd0, acc_mode});
                chk("m_memWE", {31'd0, mem_WE}, {31'd0, acc_we && ok});
                rsp_pend = 1; rsp_cyc = cyc + 1; rsp_port = acc_port;
                rsp_rdata = (!acc_we && ok) ? mem_RD : 32'd0;
                rsp_err = !ok;
                acc_pend = 0;
            end else begin
                chk("m_memWE_idle", {31'd0, mem_WE}, 0);
                chk("m_memA_idle", mem_A, 0);
            end

            e_gnt = 2'b00;
            if (cyc >= free_cyc && req_i != 2'b00) begin
                if (req_i == 2'b11) w = (m_last == 1) ? 0 : 1;
                else                w = req_i[1] ? 1 : 0;
                e_gnt = (w == 1) ? 2'b10 : 2'b01;
                acc_pend = 1; acc_cyc = cyc + 1; acc_port = w;
                acc_we    = (w == 1) ? we_i[1]  : we_i[0];
                acc_mode  = (w == 1) ? mode1_i  : mode0_i;
                acc_addr  = (w == 1) ? addr1_i  : addr0_i;
                acc_wdata = (w == 1) ? wdata1_i : wdata0_i;
                free_cyc = cyc + 2; m_last = w;
            end
            chk("m_gnt", {30'd0, gnt_o}, {30'd0, e_gnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(); rst_n = 1'b0; req_i = 2'b00;
        tick(); tick(); rst_n = 1'b1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 1) begin
            we_i[1] = we; mode1_i = mode; addr1_i = addr; wdata1_i = wdata;
        end else begin
            we_i[0] = we; mode0_i = mode; addr0_i = addr; wdata0_i = wdata;
        end
    endtask

    task automatic txn(input int p, input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [1:0] oh;
        oh = (p == 1) ? 2'b10 : 2'b01;
        tick(); set_port(p, we, mode, addr, wdata); req_i = oh; mem_RD = rd;
        @(negedge clk); chk("t_gnt", {30'd0, gnt_o}, {30'd0, oh});
        tick(); req_i = 2'b00;
        @(negedge clk);
        chk("t_memWE", {31'd0, mem_WE}, {31'd0, we & ~exp_err});
        chk("t_memA", mem_A, addr);
        chk("t_memmode", {29'd0, mem_mode}, {29'd0, mode});
        tick();
        @(negedge clk);
        chk("t_rvalid", {30'd0, rvalid_o}, {30'd0, oh});
        chk("t_rdata", rdata_o, exp_rd);
        chk("t_err", {31'd0, err_o}, {31'd0, exp_err});
    endtask

    initial begin
        model_reset();
        tick(); tick();
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt_o}, 0);
        rst_n = 1'b1;

        txn(0, 1'b0, 3'b001, 32'h40, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        // Contention right after reset: port 0 must win the first tie.
        do_reset();
        tick(); req_i = 2'b11; mem_RD = 32'h12345678;
        set_port(0, 1'b0, 3'b001, 32'h44, 32'h0);
        set_port(1, 1'b0, 3'b100, 32'h48, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("c_gnt", {30'd0, gnt_o}, ((k / 2) % 2 == 1) ? 32'd2 : 32'd1);
                if (k >= 2) chk("c_rvalid", {30'd0, rvalid_o}, (((k / 2) - 1) % 2 == 1) ? 32'd2 : 32'd1);
            end else begin
                chk("c_gnt_gap", {30'd0, gnt_o}, 0);
            end
            tick();
        end
        req_i = 2'b00;
        @(negedge clk); chk("c_rvalid_last", {30'd0, rvalid_o}, 32'd2);

        txn(1, 1'b1, 3'b011, 32'h20, 32'h000000AB, 32'hCAFE0000, 32'h0, 1'b0);
        txn(0, 1'b1, 3'b001, 32'h100, 32'h11111111, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b0, 3'b110, 32'h50, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn(0, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1, 32'h1, 1'b0);
        txn(1, 1'b0, 3'b000, 32'h54, 32'h0, 32'h77, 32'h0, 1'b1);

        // Withdrawn request: port 1 asks during ACCESS and leaves before IDLE.
        tick(); set_port(0, 1'b0, 3'b101, 32'h60, 32'h0); req_i = 2'b01; mem_RD = 32'h80;
        @(negedge clk); chk("w_gnt0", {30'd0, gnt_o}, 32'd1);
        tick(); set_port(1, 1'b0, 3'b001, 32'h64, 32'h0); req_i = 2'b10;
        @(negedge clk); chk("w_gnt_access", {30'd0, gnt_o}, 0);
        tick(); req_i = 2'b00;
        @(negedge clk);
        chk("w_gnt_idle", {30'd0, gnt_o}, 0);
        chk("w_rdata", rdata_o, 32'h80);
        tick(); req_i = 2'b11;
        @(negedge clk); chk("w_tie", {30'd0, gnt_o}, 32'd2);
        tick(); req_i = 2'b00;
        tick(); tick();

        // Reset asserted asynchronously in the middle of a write's ACCESS cycle.
        tick(); set_port(0, 1'b1, 3'b001, 32'h30, 32'h55); req_i = 2'b01;
        @(negedge clk); chk("r_gnt", {30'd0, gnt_o}, 32'd1);
        tick(); req_i = 2'b00;
        #1; chk("r_memWE_before", {31'd0, mem_WE}, 32'd1);
        rst_n = 1'b0;
        #1; chk("r_memWE_after", {31'd0, mem_WE}, 0);
        tick(); tick(); rst_n = 1'b1;
        @(negedge clk); chk("r_no_rvalid", {30'd0, rvalid_o}, 0);
        tick(); set_port(1, 1'b0, 3'b001, 32'h70, 32'h0); req_i = 2'b11;
        @(negedge clk); chk("r_tie", {30'd0, gnt_o}, 32'd1);
        tick(); req_i = 2'b00;
        tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: port 0 (pipeline MEM stage) and port 1 (debug/loader).
- Round-robin arbitration, one transaction in flight, registered response.
- Sits between the requesters and the data memory. It drives the memory's address, write data, write enable and access-mode inputs, and samples its combinational read data.

Parameters:
- WIDTH, 32, data and address width.
- STATUS_ADDR, 32'h100, read-only trigger/status address; writes to it are rejected.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  2  per-port request; bit0 = port 0, bit1 = port 1
- we_i  in  2  per-port write enable
- mode0_i, mode1_i  in  3 each  access mode: 001 W, 010 H, 011 B, 100 HU, 101 BU
- addr0_i, addr1_i  in  WIDTH each  byte address
- wdata0_i, wdata1_i  in  WIDTH each  store data
- gnt_o  out  2  one-hot grant pulse; request accepted this cycle
- rvalid_o  out  2  one-hot response pulse
- rdata_o  out  WIDTH  load data, shared by both ports, qualified by rvalid_o
- err_o  out  1  response error flag, qualified by rvalid_o
- mem_A  out  WIDTH  memory address
- mem_WD  out  WIDTH  memory write data
- mem_WE  out  1  memory write enable
- mem_mode  out  3  memory access mode
- mem_RD  in  WIDTH  memory combinational read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_gnt=1 (so port 0 wins the first tie), gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
- Memory outputs in IDLE and on reset: mem_WE=0, mem_A/mem_WD/mem_mode=0.
- Assertion mid-ACCESS discards the transaction; no response is issued.
- States: IDLE, ACCESS.
- IDLE:
  - Pick a winner among req_i.
  - Single requester: it wins.
  - Both requesting: the port != last_gnt wins.
  - gnt_o is combinational, one-hot, asserted in IDLE only.
  - On the same edge, latch the winner's we/mode/addr/wdata into the command register, update last_gnt, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_A/mem_WD/mem_mode driven from the command register.
  - mem_WE = cmd_we AND cmd_ok.
  - At the edge: rdata_o <= (read AND cmd_ok) ? mem_RD : 0; err_o <= !cmd_ok.
  - rvalid_o <= one-hot of the granted port, for one cycle. Writes also receive rvalid_o, as an acknowledgement with rdata_o=0.
  - Next state is IDLE.
- Response timing: rvalid_o is high in the cycle after ACCESS, coinciding with the next IDLE. A new grant may be given in that same cycle.
- Latency and throughput: request seen in IDLE at cycle N, grant at N, response at N+2. Maximum throughput is one access per 2 cycles.
- cmd_ok is false in either case:
  - mode is in {000, 110, 111};
  - write to addr == STATUS_ADDR.
- A failed command gets no memory write, rdata_o=0, err_o=1. Reads of STATUS_ADDR are legal and return mem_RD.
- Requester rules:
  - req must stay high, with stable fields, until gnt.
  - Dropping req before gnt is allowed and simply withdraws it.
  - A requester may re-request in the cycle its rvalid arrives.
- Requests arriving during ACCESS are not granted until IDLE.
- Fairness: with both ports continuously requesting, grants strictly alternate. Neither port waits more than one transaction.
- rvalid_o and gnt_o are never both set for the same port in a given cycle unless back-to-back; that case is legal.

Decomposition:
- Package dmem_pkg:
  - mode localparams MODE_W=3'b001, MODE_H=3'b010, MODE_B=3'b011, MODE_HU=3'b100, MODE_BU=3'b101;
  - state enum arb_state_t {IDLE, ACCESS};
  - command struct {we, mode, addr, wdata}.
- One sub-module is natural: rr_arbiter2. It is combinational, taking req[1:0] and last[0:0] and producing gnt[1:0] one-hot.
- The FSM, command register and response registers stay in dmem_arbiter.

Test Plan:
- Reset then a single read: port 0 reads addr 0x40, mode 001, mem_RD=32'hDEADBEEF. Required: gnt_o=01 at cycle 0, mem_WE=0 at cycle 1, rvalid_o=01 with rdata_o=DEADBEEF and err_o=0 at cycle 2.
- Contention: both ports request from cycle 0, held high. Required: grants 01,10,01,10 at cycles 0,2,4,6, with rvalid_o matching 2 cycles after each grant.
- Write path: port 1 writes wdata=32'h000000AB, mode 011, addr 0x20. Required: exactly one cycle with mem_WE=1, mem_A=0x20, mem_mode=011; then rvalid_o=10, rdata_o=0, err_o=0.
- Illegal commands:
  - Port 0 writes addr 0x100. Required: mem_WE stays 0; rvalid_o=01, err_o=1.
  - Mode 110 read. Required: rvalid_o=01, err_o=1, rdata_o=0.
  - Read of 0x100 with mem_RD=1. Required: rdata_o=1, err_o=0.
- Reset mid-ACCESS: pull rst_n low during a port 0 write's ACCESS cycle, asynchronously, before the edge. Required: mem_WE drops to 0 immediately; no rvalid_o after release; the first post-reset tie grants port 0.
- Withdrawn request: port 1 raises req during port 0's ACCESS, then drops it before IDLE. Required: no grant to port 1 and the FSM stays IDLE. last_gnt stays 0, so the next tie grants port 1.
